// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive byte queues.
//   UART_DATA_W      : width of one UART data byte
//   UART_QUEUE_DEPTH : default queue depth
//   queue_level_w()  : bits needed to hold an occupancy of 0..depth
//   queue_level_t    : occupancy type for the default depth
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_QUEUE_DEPTH = 16;

  // Occupancy must reach DEPTH itself, hence one bit more than the pointer.
  function automatic int queue_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(UART_QUEUE_DEPTH):0] queue_level_t;

endpackage

// File: rtl/uart_tx_queue_ram.sv
// DEPTH x UART_DATA_W byte storage for the transmit queue.
//   clk_i   : system clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (asynchronous read)
//   rdata_o : byte at raddr_i
// Contents are deliberately not reset; the queue never reads a slot it has
// not written.
module uart_byte_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [UART_DATA_W-1:0] rdata_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding the UART transmitter.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   wr_en_i       : push strobe, wr_data_i is the byte pushed
//   flush_i       : discard everything except the committed head byte
//   ovf_clr_i     : clear the sticky overflow flag
//   tx_done_i     : transmitter finished the head byte's frame (pop)
//   full_o        : level_o == DEPTH
//   empty_o       : level_o == 0
//   level_o       : occupancy 0..DEPTH
//   overflow_o    : sticky, a push was dropped because the queue was full
//   data_send_o   : head byte, 0 when empty
//   ena_tx_o      : transmit request, high while non-empty
// Queue state (EMPTY / ACTIVE / FULL) is implied by level_q alone.
// Outputs depend only on registers so the transmitter never sees a
// combinational path from the strobes.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [UART_DATA_W-1:0]       wr_data_i,
  input  logic                         flush_i,
  input  logic                         ovf_clr_i,
  input  logic                         tx_done_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [queue_level_w(DEPTH)-1:0] level_o,
  output logic                         overflow_o,
  output logic [UART_DATA_W-1:0]       data_send_o,
  output logic                         ena_tx_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = queue_level_w(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_addr;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full, empty;
  logic          pop, flush_hit, push, drop;
  logic [UART_DATA_W-1:0] head_byte;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  // full is the registered value: a pop in the same cycle does not make
  // room for a push.
  assign pop       = tx_done_i & ~empty;
  assign flush_hit = flush_i & ~empty;
  assign push      = wr_en_i & ~full;
  assign drop      = wr_en_i & full;

  // Resolution order: pop, then flush, then push.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q - LW'(pop);
    wr_addr  = wr_ptr_q;
    if (flush_hit) begin
      // Keep only the head; if it was popped this cycle nothing remains.
      // rd_ptr_q + 1 is the slot right behind the head (or the new head).
      wr_addr = rd_ptr_q + PW'(1);
      level_d = pop ? '0 : LW'(1);
    end
    wr_ptr_d = wr_addr;
    if (push) begin
      wr_ptr_d = wr_addr + PW'(1);
      level_d  = level_d + LW'(1);
    end
    // A drop in the same cycle as a clear leaves the flag set.
    overflow_d = drop | (overflow_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  uart_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_addr),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_byte)
  );

  assign full_o      = full;
  assign empty_o     = empty;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign ena_tx_o    = ~empty;
  assign data_send_o = empty ? '0 : head_byte;

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i, flush_i, ovf_clr_i, tx_done_i;
  logic [7:0] wr_data_i;
  logic       full_o, empty_o, overflow_o, ena_tx_o;
  logic [2:0] level_o;
  logic [7:0] data_send_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .flush_i     (flush_i),
    .ovf_clr_i   (ovf_clr_i),
    .tx_done_i   (tx_done_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .data_send_o (data_send_o),
    .ena_tx_o    (ena_tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs are applied one time unit after a rising edge and held for one
  // cycle. The scoreboard is updated at issue time: flush trims to the head
  // (the monitor still pops it if tx_done is also set), then an accepted push
  // is appended. Full is judged on the pre-cycle occupancy.
  task automatic drive(input logic we, input logic [7:0] d, input logic fl,
                       input logic td, input logic oc);
    bit was_full;
    was_full = (exp_q.size() == DEPTH);
    if (fl && exp_q.size() > 0)
      while (exp_q.size() > 1) void'(exp_q.pop_back());
    if (we && !was_full) exp_q.push_back(d);
    wr_en_i = we; wr_data_i = d; flush_i = fl; tx_done_i = td; ovf_clr_i = oc;
    @(posedge clk_i);
    #1;
    wr_en_i = 0; wr_data_i = 0; flush_i = 0; tx_done_i = 0; ovf_clr_i = 0;
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: every frame completion is compared against the scoreboard head.
  always @(negedge clk_i) begin
    if (!rst_i && tx_done_i && ena_tx_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no byte", data_send_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_send_o !== e) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", data_send_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; wr_en_i = 0; wr_data_i = 0; flush_i = 0; ovf_clr_i = 0; tx_done_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;

    // Reset values
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_ena", ena_tx_o, 0);
    chk("rst_data", data_send_o, 0);
    chk("rst_ovf", overflow_o, 0);

    // Three bytes, tx_done every 20 cycles
    push(8'h41);
    chk("t1_ena_rise", ena_tx_o, 1);
    chk("t1_head", data_send_o, 8'h41);
    push(8'h42);
    push(8'h43);
    chk("t1_level3", level_o, 3);
    for (int k = 0; k < 3; k++) begin
      repeat (19) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      pop1();
    end
    chk("t1_empty", empty_o, 1);
    chk("t1_ena_fall", ena_tx_o, 0);
    chk("t1_data0", data_send_o, 0);

    // Fill to DEPTH, overflow, clear, drop with simultaneous pop, set-wins
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    chk("f_full", full_o, 1);
    chk("f_level4", level_o, 4);
    chk("f_ovf0", overflow_o, 0);
    push(8'h99);
    chk("f_ovf_set", overflow_o, 1);
    chk("f_level_hold", level_o, 4);
    chk("f_head", data_send_o, 8'h11);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("f_ovf_clr", overflow_o, 0);
    drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("f_drop_pop_level", level_o, 3);
    chk("f_drop_pop_ovf", overflow_o, 1);
    chk("f_drop_pop_full", full_o, 0);
    push(8'h15);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("f_ovf_clr2", overflow_o, 0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("f_set_wins", overflow_o, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) pop1();
    chk("f_drained", empty_o, 1);

    // Wrap: 10 bytes through the 4-deep queue, pushes interleaved with pops
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h60 + 8'(i), 1'b0, (i >= 2), 1'b0);
      chk("w_level", level_o, (i < 2) ? i + 1 : 2);
    end
    pop1(); pop1();
    chk("w_empty", empty_o, 1);

    // Flush keeps the committed head
    push(8'h10); push(8'h20); push(8'h30);
    chk("fl_level3", level_o, 3);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fl_level1", level_o, 1);
    chk("fl_head", data_send_o, 8'h10);
    pop1();
    chk("fl_empty", empty_o, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fl_on_empty", level_o, 0);
    push(8'h21); push(8'h22);
    drive(1'b1, 8'h23, 1'b1, 1'b0, 1'b0);
    chk("fl_push_level", level_o, 2);
    chk("fl_push_head", data_send_o, 8'h21);
    pop1();
    chk("fl_push_next", data_send_o, 8'h23);
    pop1();

    // Same-cycle events
    push(8'h31);
    drive(1'b1, 8'h32, 1'b0, 1'b1, 1'b0);
    chk("sc_pp_level", level_o, 1);
    chk("sc_pp_head", data_send_o, 8'h32);
    push(8'h33);
    drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    chk("sc_fpp_level", level_o, 1);
    chk("sc_fpp_head", data_send_o, 8'h55);
    pop1();
    chk("sc_empty", empty_o, 1);
    pop1();
    chk("sc_pop_empty", level_o, 0);

    // Reset mid-stream
    push(8'h71); push(8'h72); push(8'h73);
    chk("r_level3", level_o, 3);
    #1 rst_i = 1;
    #1;
    chk("r_level", level_o, 0);
    chk("r_empty", empty_o, 1);
    chk("r_ena", ena_tx_o, 0);
    chk("r_data", data_send_o, 0);
    chk("r_full", full_o, 0);
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 0;
    pop1();
    chk("r_pop_empty", level_o, 0);
    chk("r_pop_ena", ena_tx_o, 0);

    chk("sb_all_sent", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
